temporal_encoder: RTL and testbench

Binary-to-temporal encoder: accepts one packed vector of N_CH binary values per gamma cycle over a valid/ready handshake and emits, for each channel, a race-logic event whose arrival time within the next gamma cycle equals the value. It is the producer side of the temporal primitives: its outputs drive `greater_than_eq`-style operators and their latch reset, so binary test vectors and upstream logic can feed temporal networks.

---
 rtl/temporal_pkg.sv | 21 ++
 rtl/temporal_lane.sv | 38 +++
 rtl/temporal_encoder.sv | 106 ++++++++++
 tb/tb_temporal_encoder.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/temporal_pkg.sv
// Shared types and helpers for the temporal (race-logic) encoder family.
// Latency: none (package only).
// Backpressure: none (package only).
package temporal_pkg;

    // Width of one channel value: enough for 0..gamma, so gamma itself encodes infinity.
    function automatic int val_w(input int gamma);
        return $clog2(gamma) + 1;
    endfunction

    // A value at or beyond the gamma length means "no event this gamma cycle".
    function automatic logic is_inf(input logic [31:0] v, input int unsigned gamma);
        return (v >= gamma);
    endfunction

    localparam int DEF_GAMMA = 16;

    // Per-channel value at the default gamma length.
    typedef logic [val_w(DEF_GAMMA)-1:0] tval_t;

endpackage

// File: rtl/temporal_lane.sv
// One channel: turns the active value and the phase into a spike bit (pulse or step, PULSE_MODE_EN).
// Latency: combinational; the parent registers the result.
// Backpressure: none.
module temporal_lane import temporal_pkg::*; #(
    parameter int VAL_W             = 5,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8
) (
    input  logic [VAL_W-1:0] t_i,
    input  logic [VAL_W-1:0] val_i,
    output logic             spike_o
);

`ifdef PULSE_MODE_EN
    localparam bit PULSE_MODE = 1'b1;
`else
    localparam bit PULSE_MODE = 1'b0;
`endif

    // Step mode is a pulse that always reaches the gamma boundary; t never exceeds G-1,
    // so a span of G can never end the step early.
    localparam int SPAN = PULSE_MODE ? PULSE_WIDTH : GAMMA_CYCLE_WIDTH;

    logic [31:0] t32;
    logic [31:0] v32;

    assign t32 = 32'(t_i);
    assign v32 = 32'(val_i);

    // Event is high from t=v until the span ends; truncation at the boundary is implicit.
    always_comb begin
        spike_o = 1'b0;
        if (!is_inf(v32, GAMMA_CYCLE_WIDTH) && (t32 >= v32) && (t32 < v32 + 32'(SPAN))) begin
            spike_o = 1'b1;
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// Binary-to-temporal encoder: one N_CH vector per gamma cycle becomes race-logic events (PULSE_MODE_EN selects pulse vs step).
// Latency: a vector accepted in gamma cycle k is emitted in the next gamma cycle after it reaches active; all outputs registered.
// Backpressure: in_ready drops while the shadow register is full, except in the last phase when shadow drains into active.
module temporal_encoder import temporal_pkg::*; #(
    parameter int N_CH              = 4,
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VAL_W             = val_w(GAMMA_CYCLE_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    grst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [N_CH*VAL_W-1:0]   in_data,
    output logic                    gamma_rst,
    output logic [N_CH-1:0]         spike,
    output logic                    underrun
);

    localparam int               DW     = N_CH * VAL_W;
    localparam logic [VAL_W-1:0] T_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);
    localparam logic [VAL_W-1:0] V_INF  = VAL_W'(GAMMA_CYCLE_WIDTH);

    logic [VAL_W-1:0] t_q, t_d;
    logic             first_q;
    logic             full_q, full_d;
    logic [DW-1:0]    shadow_q, shadow_d;
    logic [DW-1:0]    active_q, active_d;
    logic             gamma_rst_q;
    logic             underrun_q;
    logic [N_CH-1:0]  spike_q, spike_d;
    logic [DW-1:0]    all_inf;
    logic             last_cyc;
    logic             accept;

    assign last_cyc = (t_q == T_LAST);
    assign in_ready = ~full_q | last_cyc;
    assign accept   = in_valid & in_ready;

    // Constant vector with every channel at infinity.
    always_comb begin
        all_inf = '0;
        for (int i = 0; i < N_CH; i++) begin
            all_inf[i*VAL_W +: VAL_W] = V_INF;
        end
    end

    // Phase advance, shadow-to-active transfer at the last phase, and shadow load on handshake.
    // An accept in the last phase lands in shadow after the old contents moved on.
    always_comb begin
        t_d      = last_cyc ? '0 : t_q + VAL_W'(1);
        active_d = active_q;
        shadow_d = shadow_q;
        full_d   = full_q;
        if (last_cyc) begin
            active_d = full_q ? shadow_q : all_inf;
            full_d   = 1'b0;
        end
        if (accept) begin
            shadow_d = in_data;
            full_d   = 1'b1;
        end
    end

    // Lanes see the next phase and next active vector so spikes register in step with gamma_rst.
    for (genvar g = 0; g < N_CH; g++) begin : g_lane
        temporal_lane #(
            .VAL_W             (VAL_W),
            .GAMMA_CYCLE_WIDTH (GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH       (PULSE_WIDTH)
        ) u_lane (
            .t_i     (t_d),
            .val_i   (active_d[g*VAL_W +: VAL_W]),
            .spike_o (spike_d[g])
        );
    end

    // State and output registers; reset parks the phase at the last slot so the next cycle starts a gamma.
    // first_q hides the underrun that the empty post-reset shadow would otherwise report.
    always_ff @(posedge aclk) begin
        if (grst) begin
            t_q         <= T_LAST;
            first_q     <= 1'b1;
            full_q      <= 1'b0;
            shadow_q    <= '0;
            active_q    <= all_inf;
            gamma_rst_q <= 1'b0;
            underrun_q  <= 1'b0;
            spike_q     <= '0;
        end else begin
            t_q         <= t_d;
            first_q     <= 1'b0;
            full_q      <= full_d;
            shadow_q    <= shadow_d;
            active_q    <= active_d;
            gamma_rst_q <= last_cyc;
            underrun_q  <= last_cyc & ~full_q & ~first_q;
            spike_q     <= spike_d;
        end
    end

    assign gamma_rst = gamma_rst_q;
    assign underrun  = underrun_q;
    assign spike     = spike_q;

endmodule

// File: tb/tb_temporal_encoder.sv
// Self-checking bench for temporal_encoder: scoreboard of accepted vectors, per-cycle output checks.
// Latency: n/a.
// Backpressure: n/a.
module tb_temporal_encoder;
    import temporal_pkg::*;

    localparam int N_CH = 4;
    localparam int G    = 16;
    localparam int PW   = 8;
    localparam int VW   = val_w(G);
    localparam int DW   = N_CH * VW;

`ifdef PULSE_MODE_EN
    localparam bit PULSE_MODE = 1'b1;
`else
    localparam bit PULSE_MODE = 1'b0;
`endif

    logic            aclk = 1'b0;
    logic            grst;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic            gamma_rst;
    logic [N_CH-1:0] spike;
    logic            underrun;

    always #5 aclk = ~aclk;

    temporal_encoder #(
        .N_CH              (N_CH),
        .GAMMA_CYCLE_WIDTH (G),
        .PULSE_WIDTH       (PW)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .gamma_rst (gamma_rst),
        .spike     (spike),
        .underrun  (underrun)
    );

    typedef struct {
        logic [DW-1:0] vec;
        int            due;
    } sb_t;

    sb_t           sb_q[$];
    int            ph;
    int            gk;
    bit            first_g;
    bit            exp_under;
    logic [DW-1:0] cur_vec;
    bit            last_acc;
    int            acc_ph;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h expected %0h (phase %0d gamma %0d)", tag, obs, exp, ph, gk);
        end
    endtask

    function automatic logic [DW-1:0] inf_vec();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) r[i*VW +: VW] = VW'(G);
        return r;
    endfunction

    function automatic logic [DW-1:0] pack4(input int c0, input int c1, input int c2, input int c3);
        logic [DW-1:0] r;
        r = '0;
        r[0*VW +: VW] = VW'(c0);
        r[1*VW +: VW] = VW'(c1);
        r[2*VW +: VW] = VW'(c2);
        r[3*VW +: VW] = VW'(c3);
        return r;
    endfunction

    function automatic logic [DW-1:0] rand_vec();
        logic [DW-1:0] r;
        r = '0;
        for (int i = 0; i < N_CH; i++) r[i*VW +: VW] = VW'($urandom_range(0, G + 1));
        return r;
    endfunction

    // Expected spike lines for a vector at phase p.
    function automatic logic [N_CH-1:0] exp_spike(input logic [DW-1:0] vec, input int p);
        logic [N_CH-1:0] r;
        int v;
        r = '0;
        for (int i = 0; i < N_CH; i++) begin
            v = int'(vec[i*VW +: VW]);
            if (v < G && p >= v && p < v + (PULSE_MODE ? PW : G)) r[i] = 1'b1;
        end
        return r;
    endfunction

    // One clock: record handshake, advance the model, then check every output.
    task automatic tick();
        bit  rst_now;
        bit  popped;
        sb_t e;
        rst_now  = (grst === 1'b1);
        last_acc = !rst_now && (in_valid === 1'b1) && (in_ready === 1'b1);
        if (last_acc) begin
            e.vec  = in_data;
            e.due  = gk + 1 + ((ph == G - 1) ? 1 : 0);
            acc_ph = ph;
            sb_q.push_back(e);
        end
        @(posedge aclk);
        #1;
        exp_under = 1'b0;
        if (rst_now) begin
            sb_q.delete();
            ph      = G - 1;
            gk      = -1;
            first_g = 1'b1;
            cur_vec = inf_vec();
        end else begin
            ph = (ph == G - 1) ? 0 : ph + 1;
            if (ph == 0) begin
                gk++;
                popped = 1'b0;
                if (sb_q.size() > 0 && sb_q[0].due == gk) begin
                    cur_vec = sb_q[0].vec;
                    void'(sb_q.pop_front());
                    popped = 1'b1;
                end else begin
                    cur_vec = inf_vec();
                end
                exp_under = !popped && !first_g;
                first_g   = 1'b0;
            end
        end
        check_eq("gamma_rst", 32'(gamma_rst), 32'(ph == 0));
        check_eq("underrun", 32'(underrun), 32'(exp_under));
        check_eq("spike", 32'(spike), 32'(exp_spike(cur_vec, ph)));
        check_eq("in_ready", 32'(in_ready), 32'((sb_q.size() == 0) || (ph == G - 1)));
    endtask

    task automatic wait_ph(input int k);
        while (ph != k) tick();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int n_under;
        grst     = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        ph       = G - 1;
        gk       = -1;
        first_g  = 1'b1;
        cur_vec  = inf_vec();
        tick();
        grst = 1'b0;

        // Idle for three gamma cycles: underrun only on the 2nd and 3rd gamma_rst.
        repeat (3 * G) tick();

        // Single vector offered at t=3, including a truncated and an infinite channel.
        wait_ph(3);
        in_data  = pack4(0, 5, 15, 16);
        in_valid = 1'b1;
        tick();
        check_eq("accept_t3", 32'(last_acc), 32'd1);
        in_valid = 1'b0;
        repeat (2 * G) tick();

        // Back-to-back: second vector waits for the last phase.
        wait_ph(3);
        in_data  = pack4(1, 3, 7, 12);
        in_valid = 1'b1;
        tick();
        in_data = pack4(9, 0, 14, 2);
        n = 0;
        do begin
            tick();
            n++;
        end while (!last_acc && n < 2 * G);
        check_eq("b2b_accepted", 32'(last_acc), 32'd1);
        check_eq("b2b_accept_ph", 32'(acc_ph), 32'(G - 1));
        in_valid = 1'b0;
        repeat (3 * G) tick();

        // Reset mid-pulse with a full shadow: shadow contents must never appear.
        wait_ph(2);
        in_data  = pack4(5, 5, 16, 16);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ph(2);
        in_data  = pack4(0, 0, 0, 0);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        wait_ph(9);
        check_eq("mid_pulse_ch0", 32'(spike[0]), 32'd1);
        grst = 1'b1;
        tick();
        grst = 1'b0;
        check_eq("spike_after_grst", 32'(spike), 32'd0);
        repeat (3 * G) tick();

        // Value 10 on every channel.
        wait_ph(0);
        in_data  = pack4(10, 10, 10, 10);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2 * G) tick();

        // Sustained random traffic, a new vector after every handshake.
        n_under  = 0;
        in_data  = rand_vec();
        in_valid = 1'b1;
        for (int i = 0; i < 100 * G; i++) begin
            tick();
            if (i >= 2 * G && underrun === 1'b1) n_under++;
            if (last_acc) in_data = rand_vec();
        end
        check_eq("sustained_underrun", 32'(n_under), 32'd0);
        in_valid = 1'b0;
        repeat (3 * G) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
